// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception codes and Status/Cause bit positions
// shared by the CP0 register file and its timer.
package cp0_pkg;

    // MFC0/MTC0 register numbers (select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    // Status bit positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_BEV    = 22;

    // Cause bit positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_param_if.sv
// MTC0/MFC0 access port of the CP0 register file.
// Writes take effect at the clock edge where we_i is high; reads are a
// combinational lookup of raddr_i and always return the pre-edge value.
interface cp0_regfile_param_if;

    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;

    // Pipeline side: issues MTC0 writes and MFC0 reads
    modport master (
        output we_i,
        output waddr_i,
        output data_i,
        output raddr_i,
        input  data_o
    );

    // Register file side
    modport slave (
        input  we_i,
        input  waddr_i,
        input  data_i,
        input  raddr_i,
        output data_o
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with a Count prescaler and a sticky timer interrupt.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    // Prescaler value on which Count advances (COUNT_DIV is 1..4)
    localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

    logic [1:0]  presc;
    logic        tick;
    logic [31:0] count_inc;

    assign tick      = (presc == DIV_LAST);
    assign count_inc = count_o + 32'd1;

    // Prescaler, Count, Compare and the sticky match flag. A Count write
    // suppresses that cycle's increment (and so its match); a Compare write
    // clears the flag even if a match happens on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc       <= 2'd0;
            count_o     <= 32'd0;
            compare_o   <= 32'd0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we) begin
                count_o <= wdata;
                presc   <= 2'd0;
            end else if (tick) begin
                count_o <= count_inc;
                presc   <= 2'd0;
            end else begin
                presc <= presc + 2'd1;
            end

            if (compare_we) begin
                compare_o   <= wdata;
                timer_int_o <= 1'b0;
            end else if (tick && !count_we && (count_inc == compare_o)) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile_param.sv
// MIPS32 CP0 register file: Status/Cause/EPC/BadVAddr, exception entry,
// ERET, interrupt request generation and the MFC0 read mux. Count/Compare
// live in cp0_timer.
module cp0_regfile_param
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_regfile_param_if.slave    bus,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic                  is_in_delayslot_i,
    input  logic [31:0]           current_inst_addr_i,
    input  logic [31:0]           bad_addr_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           badvaddr_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

    // Only the writable/live fields are stored; the rest read as constants.
    logic        st_ie;
    logic        st_exl;
    logic [7:0]  st_im;
    logic        ca_bd;
    logic [4:0]  ca_exc;
    logic [1:0]  ca_sw_ip;
    logic [5:0]  hw_ip;
    logic [5:0]  int_pad;
    logic [7:0]  cause_ip;

    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    assign wr_status = bus.we_i && (bus.waddr_i == CP0_STATUS);
    assign wr_cause  = bus.we_i && (bus.waddr_i == CP0_CAUSE);
    assign wr_epc    = bus.we_i && (bus.waddr_i == CP0_EPC);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_we    (bus.we_i && (bus.waddr_i == CP0_COUNT)),
        .compare_we  (bus.we_i && (bus.waddr_i == CP0_COMPARE)),
        .wdata       (bus.data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );

    // Widen the HW interrupt lines to six; missing lines read as 0
    always_comb begin
        int_pad = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            int_pad[i] = int_i[i];
        end
    end

    // IP[7] is shared between HW line 5 and the timer
    assign cause_ip = {hw_ip[5] | timer_int_o, hw_ip[4:0], ca_sw_ip};

    // Exception entry, ERET and MTC0 updates. Exception beats ERET beats
    // MTC0 on EXL; EPC/BD are captured only on a non-nested exception.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_ie      <= 1'b0;
            st_exl     <= 1'b0;
            st_im      <= 8'd0;
            ca_bd      <= 1'b0;
            ca_exc     <= 5'd0;
            ca_sw_ip   <= 2'd0;
            hw_ip      <= 6'd0;
            epc_o      <= 32'd0;
            badvaddr_o <= 32'd0;
        end else begin
            hw_ip <= int_pad;

            if (wr_status) begin
                st_ie <= bus.data_i[STATUS_IE];
                st_im <= bus.data_i[STATUS_IM_LSB +: 8];
            end

            if (wr_cause) begin
                ca_sw_ip <= bus.data_i[CAUSE_IP_LSB +: 2];
            end

            if (exc_valid_i) begin
                st_exl <= 1'b1;
                ca_exc <= exc_code_i;
            end else if (eret_i) begin
                st_exl <= 1'b0;
            end else if (wr_status) begin
                st_exl <= bus.data_i[STATUS_EXL];
            end

            if (exc_valid_i && !st_exl) begin
                epc_o <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                           : current_inst_addr_i;
                ca_bd <= is_in_delayslot_i;
            end else if (wr_epc) begin
                epc_o <= bus.data_i;
            end

            if (exc_valid_i && is_addr_exc(exc_code_i)) begin
                badvaddr_o <= bad_addr_i;
            end
        end
    end

    // Assemble the architectural Status and Cause views
    always_comb begin
        status_o                         = 32'd0;
        status_o[STATUS_IE]              = st_ie;
        status_o[STATUS_EXL]             = st_exl;
        status_o[STATUS_IM_LSB +: 8]     = st_im;
        status_o[STATUS_BEV]             = 1'b1;

        cause_o                          = 32'd0;
        cause_o[CAUSE_EXC_LSB +: 5]      = ca_exc;
        cause_o[CAUSE_IP_LSB +: 8]       = cause_ip;
        cause_o[CAUSE_TI]                = timer_int_o;
        cause_o[CAUSE_BD]                = ca_bd;
    end

    assign int_req_o = st_ie & ~st_exl & (|(cause_ip & st_im));

    // MFC0 read mux; held at zero while reset is asserted
    always_comb begin
        bus.data_o = 32'd0;
        if (rst) begin
            case (bus.raddr_i)
                CP0_BADVADDR: bus.data_o = badvaddr_o;
                CP0_COUNT:    bus.data_o = count_o;
                CP0_COMPARE:  bus.data_o = compare_o;
                CP0_STATUS:   bus.data_o = status_o;
                CP0_CAUSE:    bus.data_o = cause_o;
                CP0_EPC:      bus.data_o = epc_o;
                CP0_PRID:     bus.data_o = PRID_VAL;
                CP0_CONFIG:   bus.data_o = CONFIG_VAL;
                default:      bus.data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile_param.sv
// Directed bench for cp0_regfile_param (COUNT_DIV=2, six HW lines).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cp0_regfile_param;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic        is_in_delayslot_i;
    logic [31:0] current_inst_addr_i;
    logic [31:0] bad_addr_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;
    logic        int_req_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    cp0_regfile_param_if bus ();

    cp0_regfile_param #(
        .HW_INT_NUM (6),
        .COUNT_DIV  (2),
        .PRID_VAL   (32'h004C0102),
        .CONFIG_VAL (32'h00008000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .int_i               (int_i),
        .exc_valid_i         (exc_valid_i),
        .exc_code_i          (exc_code_i),
        .eret_i              (eret_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .current_inst_addr_i (current_inst_addr_i),
        .bad_addr_i          (bad_addr_i),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .badvaddr_o          (badvaddr_o),
        .timer_int_o         (timer_int_o),
        .int_req_o           (int_req_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and stop on the following falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.data_i  = d;
        step(1);
        bus.we_i    = 1'b0;
    endtask

    task automatic exception(input logic [4:0] code, input logic ds,
                             input logic [31:0] pc, input logic [31:0] bad,
                             input logic with_eret);
        exc_valid_i         = 1'b1;
        exc_code_i          = code;
        is_in_delayslot_i   = ds;
        current_inst_addr_i = pc;
        bad_addr_i          = bad;
        eret_i              = with_eret;
        step(1);
        exc_valid_i         = 1'b0;
        eret_i              = 1'b0;
    endtask

    initial begin
        // Reset block
        rst                 = 1'b0;
        int_i               = 6'd0;
        exc_valid_i         = 1'b0;
        exc_code_i          = 5'd0;
        eret_i              = 1'b0;
        is_in_delayslot_i   = 1'b0;
        current_inst_addr_i = 32'd0;
        bad_addr_i          = 32'd0;
        bus.we_i            = 1'b0;
        bus.waddr_i         = 5'd0;
        bus.data_i          = 32'd0;
        bus.raddr_i         = 5'd12;
        @(negedge clk);
        step(2);

        check("rst_count",  count_o,            32'd0);
        check("rst_status", status_o,           32'h0040_0000);
        check("rst_cause",  cause_o,            32'd0);
        check("rst_timer",  {31'd0, timer_int_o}, 32'd0);
        check("rst_rdata",  bus.data_o,         32'd0);

        // Count advances every second cycle
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) exp_q.push_back(32'(i / 2));
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check("count_run", count_o, exp_q.pop_front());
        end
        bus.raddr_i = 5'd9;
        #1;
        check("mfc0_count", bus.data_o, 32'd5);

        // Count wrap; Compare==0 matches on the wrap
        mtc0(5'd9, 32'hFFFF_FFFE);
        check("count_wr", count_o, 32'hFFFF_FFFE);
        step(4);
        check("count_wrap", count_o, 32'd0);
        check("timer_wrap", {31'd0, timer_int_o}, 32'd1);

        // Compare=20: clears flag, rises when Count becomes 20
        mtc0(5'd11, 32'd20);
        check("cmp_clear", {31'd0, timer_int_o}, 32'd0);
        step(38);
        check("count_19", count_o, 32'd19);
        check("timer_pre", {31'd0, timer_int_o}, 32'd0);
        step(1);
        check("count_20", count_o, 32'd20);
        check("timer_hit", {31'd0, timer_int_o}, 32'd1);
        check("cause_ti", {31'd0, cause_o[30]}, 32'd1);
        check("cause_ip7", {31'd0, cause_o[15]}, 32'd1);

        // Compare write on the matching tick keeps the flag clear
        mtc0(5'd11, 32'd21);
        check("cmp_clr2", {31'd0, timer_int_o}, 32'd0);
        mtc0(5'd11, 32'd21);
        check("count_21", count_o, 32'd21);
        check("cmp_race", {31'd0, timer_int_o}, 32'd0);

        // HW interrupt 0 with IE and IM[2]
        int_i = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        check("cause_ip2", {31'd0, cause_o[10]}, 32'd1);
        check("int_req_on", {31'd0, int_req_o}, 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        check("status_exl", status_o, 32'h0040_0403);
        check("int_req_exl", {31'd0, int_req_o}, 32'd0);
        int_i = 6'd0;
        mtc0(5'd12, 32'h0000_0401);

        // Address error in a delay slot
        exception(5'd4, 1'b1, 32'hBFC0_0104, 32'h1234_5671, 1'b0);
        check("exc1_epc", epc_o, 32'hBFC0_0100);
        check("exc1_bd", {31'd0, cause_o[31]}, 32'd1);
        check("exc1_code", {27'd0, cause_o[6:2]}, 32'd4);
        check("exc1_bad", badvaddr_o, 32'h1234_5671);
        check("exc1_exl", {31'd0, status_o[1]}, 32'd1);

        // Nested overflow: EPC/BD/BadVAddr held
        exception(5'd12, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0);
        check("exc2_epc", epc_o, 32'hBFC0_0100);
        check("exc2_bd", {31'd0, cause_o[31]}, 32'd1);
        check("exc2_code", {27'd0, cause_o[6:2]}, 32'd12);
        check("exc2_bad", badvaddr_o, 32'h1234_5671);

        // ERET, then ERET colliding with an exception
        eret_i = 1'b1;
        step(1);
        eret_i = 1'b0;
        check("eret_exl", {31'd0, status_o[1]}, 32'd0);
        exception(5'd8, 1'b0, 32'h0000_0300, 32'd0, 1'b1);
        check("exc_eret_exl", {31'd0, status_o[1]}, 32'd1);
        check("exc_eret_epc", epc_o, 32'h0000_0300);
        check("exc_eret_bd", {31'd0, cause_o[31]}, 32'd0);

        // ERET beats MTC0 on EXL; IE/IM still written
        eret_i = 1'b1;
        mtc0(5'd12, 32'h0000_0003);
        eret_i = 1'b0;
        check("eret_vs_mtc0", status_o, 32'h0040_0001);

        // Status write mask and read mux
        mtc0(5'd12, 32'hFFFF_FFFF);
        check("status_mask", status_o, 32'h0040_FF03);
        bus.raddr_i = 5'd12;
        #1;
        check("mfc0_status", bus.data_o, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_sw_ip", cause_o, 32'h0000_0320);
        mtc0(5'd15, 32'd0);
        bus.raddr_i = 5'd15;
        #1;
        check("mfc0_prid", bus.data_o, 32'h004C_0102);
        bus.raddr_i = 5'd16;
        #1;
        check("mfc0_config", bus.data_o, 32'h0000_8000);
        bus.raddr_i = 5'd3;
        #1;
        check("mfc0_unmapped", bus.data_o, 32'd0);
        bus.raddr_i = 5'd8;
        #1;
        check("mfc0_badvaddr", bus.data_o, 32'h1234_5671);

        // Same-cycle read of a register being written returns old value
        bus.raddr_i = 5'd14;
        bus.we_i    = 1'b1;
        bus.waddr_i = 5'd14;
        bus.data_i  = 32'hCAFE_0000;
        #1;
        check("no_forward", bus.data_o, 32'h0000_0300);
        step(1);
        bus.we_i = 1'b0;
        check("epc_wr", epc_o, 32'hCAFE_0000);

        // Mid-run reset
        bus.raddr_i = 5'd15;
        rst = 1'b0;
        step(1);
        check("rst2_count",   count_o,    32'd0);
        check("rst2_compare", compare_o,  32'd0);
        check("rst2_status",  status_o,   32'h0040_0000);
        check("rst2_cause",   cause_o,    32'd0);
        check("rst2_epc",     epc_o,      32'd0);
        check("rst2_bad",     badvaddr_o, 32'd0);
        check("rst2_timer",   {31'd0, timer_int_o}, 32'd0);
        check("rst2_intreq",  {31'd0, int_req_o},   32'd0);
        check("rst2_rdata",   bus.data_o, 32'd0);

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
